// File: rtl/dlsc_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dlsc_uart_tx_arbiter
//  Description : Round-robin arbiter that shares one UART transmit FIFO push
//                interface among REQUESTERS packet sources. A grant is held
//                for a whole packet (until the byte flagged last). A stall
//                timeout reclaims the grant from a source that goes quiet
//                mid-packet.
//                Optional macro DLSC_UART_ARB_GAP_EN inserts GAP idle cycles
//                after every completed packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module dlsc_uart_tx_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int DATA       = 8,
    parameter int TIMEOUT    = 1024,
    parameter int GAP        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQUESTERS-1:0]      in_valid,
    input  logic [REQUESTERS*DATA-1:0] in_data,
    input  logic [REQUESTERS-1:0]      in_last,
    output logic [REQUESTERS-1:0]      in_ready,
    output logic                       tx_push,
    output logic [DATA-1:0]            tx_data,
    input  logic                       tx_full,
    output logic [REQUESTERS-1:0]      grant,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [3:0]                 timeout_id
);

    localparam int c_IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [c_IDX_W-1:0] c_PTR_INIT = c_IDX_W'(REQUESTERS - 1);

`ifdef DLSC_UART_ARB_GAP_EN
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = (GAP > 0) ? c_GAP_W'(GAP - 1) : '0;
`endif

    // Elaboration-time sanity check of the configuration
    generate
        if (REQUESTERS < 2 || REQUESTERS > 16 || DATA < 1 || TIMEOUT < 0 || GAP < 0) begin : g_param_check
            $error("dlsc_uart_tx_arbiter: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef DLSC_UART_ARB_GAP_EN
        S_GAP   = 2'd2,
`endif
        S_GRANT = 2'd1
    } state_t;

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_ptr;
    logic [c_IDX_W-1:0]    r_owner;
    logic [REQUESTERS-1:0] r_grant;
    logic                  r_busy;
    logic                  r_terr;
    logic [3:0]            r_tid;
    logic [c_CNT_W-1:0]    r_cnt;
`ifdef DLSC_UART_ARB_GAP_EN
    logic [c_GAP_W-1:0]    r_gcnt;
`endif

    logic                  w_found;
    logic [c_IDX_W-1:0]    w_sel;
    logic [c_IDX_W-1:0]    w_cand;
    logic                  w_in_grant;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic                  w_xfer;
    logic                  w_starved;
    logic                  w_expire;
    logic                  w_done;

    // Round-robin search: first valid requester after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + k) % REQUESTERS);
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Owner-side datapath; only the owner ever sees ready, zero latency to the FIFO
    always_comb begin
        w_in_grant  = (r_state == S_GRANT);
        w_own_valid = in_valid[r_owner];
        w_own_last  = in_last[r_owner];
        w_xfer      = w_in_grant && w_own_valid && !tx_full;
        w_starved   = w_in_grant && !w_own_valid;
        w_expire    = w_starved && (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);
        w_done      = (w_xfer && w_own_last) || w_expire;
        in_ready    = (w_in_grant && !tx_full) ? r_grant : '0;
        tx_push     = w_xfer;
        tx_data     = in_data[int'(r_owner)*DATA +: DATA];
    end

    // Arbitration state machine with registered grant, status and stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= c_PTR_INIT;
            r_owner <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_terr  <= 1'b0;
            r_tid   <= '0;
            r_cnt   <= '0;
`ifdef DLSC_UART_ARB_GAP_EN
            r_gcnt  <= '0;
`endif
        end else begin
            r_terr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_GRANT;
                        r_grant <= REQUESTERS'(1) << w_sel;
                        r_owner <= w_sel;
                        r_ptr   <= w_sel;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_GRANT: begin
                    // Stall counter only advances while the owner has nothing to send;
                    // back-pressure from a full FIFO is not the owner's fault.
                    if (w_xfer) begin
                        r_cnt <= '0;
                    end else if (w_starved && (TIMEOUT != 0) && (r_cnt != c_CNT_MAX)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_expire) begin
                        r_terr <= 1'b1;
                        r_tid  <= 4'(r_owner);
                    end
                    if (w_done) begin
                        r_grant <= '0;
`ifdef DLSC_UART_ARB_GAP_EN
                        if (GAP > 0) begin
                            r_state <= S_GAP;
                            r_gcnt  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end
                end
`ifdef DLSC_UART_ARB_GAP_EN
                S_GAP: begin
                    if (r_gcnt == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_terr;
    assign timeout_id  = r_tid;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dlsc_uart_tx_arbiter
//  Description : Randomized self-checking bench for dlsc_uart_tx_arbiter.
//                Packet sources, FIFO back-pressure, quiet periods and resets
//                are random; a packet-level reference model predicts the
//                owner, status outputs and the FIFO push stream every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dlsc_uart_tx_arbiter;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int TMO  = 8;
    localparam int GAPC = 4;
`ifdef DLSC_UART_ARB_GAP_EN
    localparam int GAP_ON = 1;
`else
    localparam int GAP_ON = 0;
`endif
    localparam int CYCLES = 4000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic            tx_push;
    logic [DW-1:0]   tx_data;
    logic            tx_full;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout_err;
    logic [3:0]      timeout_id;

    dlsc_uart_tx_arbiter #(
        .REQUESTERS (N),
        .DATA       (DW),
        .TIMEOUT    (TMO),
        .GAP        (GAPC)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .tx_push     (tx_push),
        .tx_data     (tx_data),
        .tx_full     (tx_full),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: who owns the FIFO, how long they have starved it,
    // how many gap cycles remain, and the round-robin memory.
    int m_owner;    // -1 when nobody owns the FIFO
    int m_last_win; // most recently granted requester
    int m_starved;  // consecutive cycles the owner offered nothing
    int m_gap_left;
    bit m_terr;
    int m_tid;

    // Packet sources: current byte and bytes remaining in the packet
    logic [DW-1:0] src_byte [N];
    int            src_rem  [N];
    int            quiet    [N];
    int            full_burst;

    task automatic model_reset();
        m_owner    = -1;
        m_last_win = N - 1;
        m_starved  = 0;
        m_gap_left = 0;
        m_terr     = 1'b0;
        m_tid      = 0;
    endtask

    task automatic packet_over();
        m_owner    = -1;
        m_gap_left = GAP_ON ? GAPC : 0;
    endtask

    initial begin
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        bit           exp_push;

        model_reset();
        full_burst = 0;
        for (int i = 0; i < N; i++) begin
            src_byte[i] = DW'($urandom);
            src_rem[i]  = $urandom_range(1, 4);
            quiet[i]    = 0;
        end
        rst_n    = 1'b0;
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        tx_full  = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            // Registered outputs against the model's current view
            exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            check("grant",       32'(grant),       32'(exp_grant));
            check("busy",        32'(busy),        32'((m_owner >= 0) || (m_gap_left > 0)));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
            check("timeout_id",  32'(timeout_id),  32'(m_tid));

            // New stimulus
            rst_n = !((cyc < 3) || ($urandom_range(0, 299) == 0));
            for (int i = 0; i < N; i++) begin
                if (quiet[i] > 0) begin
                    quiet[i]--;
                    in_valid[i] = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    quiet[i]    = $urandom_range(4, 14);
                    in_valid[i] = 1'b0;
                end else begin
                    in_valid[i] = ($urandom_range(0, 4) != 0);
                end
                in_data[i*DW +: DW] = src_byte[i];
                in_last[i] = (src_rem[i] == 1) || (!in_valid[i] && $urandom_range(0, 3) == 0);
            end
            if (full_burst > 0) begin
                full_burst--;
                tx_full = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                full_burst = $urandom_range(10, 50);
                tx_full    = 1'b1;
            end else begin
                tx_full = ($urandom_range(0, 5) == 0);
            end

            #1;
            // Combinational outputs: only the owner is offered the FIFO
            exp_ready = (m_owner >= 0 && !tx_full) ? (N'(1) << m_owner) : '0;
            exp_push  = (m_owner >= 0) && in_valid[m_owner] && !tx_full;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("tx_push",  32'(tx_push),  32'(exp_push));
            if (exp_push) begin
                check("tx_data", 32'(tx_data), 32'(src_byte[m_owner]));
            end

            // Advance the model to what the next clock edge should produce
            m_terr = 1'b0;
            if (!rst_n) begin
                model_reset();
            end else if (m_owner >= 0) begin
                if (exp_push) begin
                    m_starved = 0;
                    if (in_last[m_owner]) packet_over();
                end else if (!in_valid[m_owner]) begin
                    m_starved++;
                    if (m_starved == TMO) begin
                        m_terr = 1'b1;
                        m_tid  = m_owner;
                        packet_over();
                    end
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && in_valid[(m_last_win + k) % N]) begin
                        m_owner    = (m_last_win + k) % N;
                        m_last_win = m_owner;
                        m_starved  = 0;
                    end
                end
            end

            // A source advances whenever its byte is taken
            for (int i = 0; i < N; i++) begin
                if (exp_ready[i] && in_valid[i]) begin
                    src_byte[i] = DW'($urandom);
                    src_rem[i]  = (src_rem[i] <= 1) ? $urandom_range(1, 4) : src_rem[i] - 1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
